// File: rtl/ym3438_dac_rx.sv
// Receives the six-slot FM channel stream, pans and sums each frame into stereo, and hands it out on valid/ready.
// Define YM3438_LADDER_EN to add the YM2612 ladder-distortion offset to every slot on both sides.
module ym3438_dac_rx #(
    parameter int NUM_SLOTS = 6,
    parameter int OUT_WIDTH = 12
) (
    input  logic                        MCLK,
    input  logic                        reset,
    input  logic [8:0]                  ch_out,
    input  logic                        smp_strobe,
    input  logic                        frame_start,
    input  logic [NUM_SLOTS-1:0]        pan_l,
    input  logic [NUM_SLOTS-1:0]        pan_r,
    output logic signed [OUT_WIDTH-1:0] out_l,
    output logic signed [OUT_WIDTH-1:0] out_r,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sync_err,
    output logic                        overrun,
    output logic                        dbg_state
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t state, state_nx;
    logic [SW-1:0] slot, slot_nx, idx;
    logic signed [OUT_WIDTH-1:0] v, acc_l, acc_r, acc_l_nx, acc_r_nx, sum_l, sum_r;
    logic take, complete, sync_err_nx;

    function automatic logic signed [OUT_WIDTH-1:0] contrib(input logic en,
                                                           input logic signed [OUT_WIDTH-1:0] s);
`ifdef YM3438_LADDER_EN
        logic signed [OUT_WIDTH-1:0] bias;
        bias = s[OUT_WIDTH-1] ? OUT_WIDTH'(-4) : OUT_WIDTH'(4);
        contrib = en ? s + bias : bias;
`else
        contrib = en ? s : '0;
`endif
    endfunction

    // Offset-binary sample: flipping the MSB yields two's complement.
    assign v = {{(OUT_WIDTH-9){~ch_out[8]}}, ~ch_out[8], ch_out[7:0]};
    assign dbg_state = state;

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        slot_nx     = slot;
        acc_l_nx    = acc_l;
        acc_r_nx    = acc_r;
        sync_err_nx = 1'b0;
        complete    = 1'b0;
        idx         = slot;
        sum_l       = acc_l;
        sum_r       = acc_r;
        take        = smp_strobe && (state == RUN || frame_start);
        if (take) begin
            // frame_start always restarts the frame, discarding any partial sum.
            idx         = frame_start ? '0 : slot;
            sum_l       = (frame_start ? '0 : acc_l) + contrib(pan_l[idx], v);
            sum_r       = (frame_start ? '0 : acc_r) + contrib(pan_r[idx], v);
            sync_err_nx = (state == RUN) && frame_start && (slot != '0);
            state_nx    = RUN;
            if (idx == LAST) begin
                complete = 1'b1;
                slot_nx  = '0;
                acc_l_nx = '0;
                acc_r_nx = '0;
            end else begin
                slot_nx  = idx + SW'(1);
                acc_l_nx = sum_l;
                acc_r_nx = sum_r;
            end
        end
    end

    // out_valid/out_l/out_r hold until a cycle with out_valid & out_ready;
    // a completion in that cycle reloads and keeps out_valid high.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            slot      <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            slot     <= slot_nx;
            acc_l    <= acc_l_nx;
            acc_r    <= acc_r_nx;
            sync_err <= sync_err_nx;
            if (complete) begin
                out_l     <= sum_l;
                out_r     <= sum_r;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ym3438_dac_rx.sv
// Directed bench for ym3438_dac_rx: framing, panning, sync recovery, handshake and overrun.
module tb_ym3438_dac_rx;
    logic MCLK = 1'b0;
    logic reset = 1'b1;
    logic [8:0] ch_out = '0;
    logic smp_strobe = 1'b0;
    logic frame_start = 1'b0;
    logic [5:0] pan_l = '0;
    logic [5:0] pan_r = '0;
    logic signed [11:0] out_l, out_r;
    logic out_valid;
    logic out_ready = 1'b0;
    logic sync_err, overrun, dbg_state;

    int passed = 0;
    int total = 0;

    ym3438_dac_rx dut (
        .MCLK(MCLK), .reset(reset), .ch_out(ch_out), .smp_strobe(smp_strobe),
        .frame_start(frame_start), .pan_l(pan_l), .pan_r(pan_r),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
        .sync_err(sync_err), .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 MCLK = ~MCLK;

    function automatic logic [8:0] enc(input int s);
        logic [8:0] t;
        t = s[8:0];
        return {~t[8], t[7:0]};
    endfunction

    task automatic do_strobe(input int s, input bit fs, input bit rdy);
        @(posedge MCLK); #1;
        ch_out = enc(s); smp_strobe = 1'b1; frame_start = fs; out_ready = rdy;
        @(posedge MCLK); #1;
        smp_strobe = 1'b0; frame_start = 1'b0; out_ready = 1'b0; ch_out = '0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge MCLK); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge MCLK);
        #1;
        total++; if (out_l !== 12'd0) $display("FAIL reset_out_l: got %0d expected 0", out_l); else passed++;
        total++; if (out_r !== 12'd0) $display("FAIL reset_out_r: got %0d expected 0", out_r); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
        total++; if (sync_err !== 1'b0) $display("FAIL reset_sync_err: got %b expected 0", sync_err); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        total++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b expected 0", dbg_state); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        pan_l = 6'h3F; pan_r = 6'h3F;
        for (int i = 0; i < 6; i++) begin
            do_strobe(1, i == 0, 1'b0);
            if (i == 4) begin
                total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", out_valid); else passed++;
            end
        end
        total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_l !== 12'sd6) $display("FAIL basic_out_l: got %0d expected 6", out_l); else passed++;
        total++; if (out_r !== 12'sd6) $display("FAIL basic_out_r: got %0d expected 6", out_r); else passed++;
        accept();
        total++; if (out_valid !== 1'b0) $display("FAIL basic_accept: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_pan();
        pan_l = 6'h3F; pan_r = 6'h00;
        for (int i = 0; i < 6; i++) begin
            do_strobe(-256, i == 0, 1'b0);
            if (i == 0) begin
                total++; if (sync_err !== 1'b0) $display("FAIL pan_no_sync_err: got %b expected 0", sync_err); else passed++;
            end
        end
        total++; if (out_l !== 12'hA00) $display("FAIL pan_neg_l: got %0d expected -1536", out_l); else passed++;
        total++; if (out_r !== 12'd0) $display("FAIL pan_neg_r: got %0d expected 0", out_r); else passed++;
        accept();
        // Distinct per-slot values 1..6; frame wraps without frame_start.
        pan_l = 6'b101010; pan_r = 6'b000111;
        for (int i = 0; i < 6; i++) do_strobe(i + 1, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) $display("FAIL pan_wrap_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_l !== 12'sd12) $display("FAIL pan_slot_l: got %0d expected 12", out_l); else passed++;
        total++; if (out_r !== 12'sd6) $display("FAIL pan_slot_r: got %0d expected 6", out_r); else passed++;
        accept();
    endtask

    task automatic test_sync();
        pan_l = 6'h3F; pan_r = 6'h3F;
        do_strobe(100, 1'b1, 1'b0);
        do_strobe(100, 1'b0, 1'b0);
        do_strobe(2, 1'b1, 1'b0);
        total++; if (sync_err !== 1'b1) $display("FAIL sync_pulse: got %b expected 1", sync_err); else passed++;
        @(posedge MCLK); #1;
        total++; if (sync_err !== 1'b0) $display("FAIL sync_pulse_end: got %b expected 0", sync_err); else passed++;
        for (int i = 0; i < 5; i++) do_strobe(2, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) $display("FAIL sync_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_l !== 12'sd12) $display("FAIL sync_out_l: got %0d expected 12", out_l); else passed++;
        accept();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) do_strobe(3, 1'b0, 1'b0);
        total++; if (out_l !== 12'sd18) $display("FAIL b2b_first: got %0d expected 18", out_l); else passed++;
        for (int i = 0; i < 6; i++) do_strobe(-2, 1'b0, i == 5);
        total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", out_valid); else passed++;
        total++; if (out_l !== 12'hFF4) $display("FAIL b2b_second: got %0d expected -12", out_l); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b expected 0", overrun); else passed++;
        accept();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drop: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 6; i++) do_strobe(1, 1'b0, 1'b0);
        total++; if (overrun !== 1'b0) $display("FAIL ovr_first: got %b expected 0", overrun); else passed++;
        for (int i = 0; i < 6; i++) do_strobe(2, 1'b0, 1'b0);
        total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", overrun); else passed++;
        total++; if (out_l !== 12'sd12) $display("FAIL ovr_out_l: got %0d expected 12", out_l); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", out_valid); else passed++;
        accept();
    endtask

    task automatic test_hunt_reset();
        for (int i = 0; i < 6; i++) do_strobe(5, 1'b0, 1'b0);
        total++; if (out_l !== 12'sd30) $display("FAIL hunt_pre: got %0d expected 30", out_l); else passed++;
        do_strobe(9, 1'b0, 1'b0);
        do_strobe(9, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL async_valid: got %b expected 0", out_valid); else passed++;
        total++; if (out_l !== 12'd0) $display("FAIL async_out_l: got %0d expected 0", out_l); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL async_overrun: got %b expected 0", overrun); else passed++;
        total++; if (dbg_state !== 1'b0) $display("FAIL async_state: got %b expected 0", dbg_state); else passed++;
        @(posedge MCLK); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) do_strobe(7, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) $display("FAIL hunt_valid: got %b expected 0", out_valid); else passed++;
        total++; if (dbg_state !== 1'b0) $display("FAIL hunt_state: got %b expected 0", dbg_state); else passed++;
        for (int i = 0; i < 6; i++) do_strobe(1, i == 0, 1'b0);
        total++; if (out_l !== 12'sd6) $display("FAIL hunt_clean_acc: got %0d expected 6", out_l); else passed++;
        accept();
    endtask

    task automatic test_ladder();
        logic [11:0] exp_l, exp_r;
`ifdef YM3438_LADDER_EN
        exp_l = 12'hFF0;
        exp_r = 12'hFF0;
`else
        exp_l = 12'h000;
        exp_r = 12'h000;
`endif
        pan_l = 6'h01; pan_r = 6'h00;
        do_strobe(0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_strobe(-1, 1'b0, 1'b0);
        total++; if (out_l !== exp_l) $display("FAIL ladder_l: got %0d expected %0d", out_l, $signed(exp_l)); else passed++;
        total++; if (out_r !== exp_r) $display("FAIL ladder_r: got %0d expected %0d", out_r, $signed(exp_r)); else passed++;
        accept();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pan();
        test_sync();
        test_back_to_back();
        test_overrun();
        test_hunt_reset();
        test_ladder();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
